// File: rtl/regfile_latched.sv
// Register file: DEPTH x WIDTH storage with one write port and two registered
// operand latches that capture with write-first bypass. Define REGFILE_TRISTATE_EN to add an oe port that tristates the read outputs.
module regfile_latched #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter logic [31:0] INIT     = 32'h0000_0000,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef REGFILE_TRISTATE_EN
    input  logic              oe,
`endif
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    output logic              rvalid
);

    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic [WIDTH-1:0] rdata2_q, rdata2_d;
    logic             rvalid_q, rvalid_d;

    logic             wr_ok;
    logic             zero1, zero2;
    logic             byp1, byp2;
    logic [WIDTH-1:0] next1, next2;

    // Next-state: write-first bypass feeds the operand latches on the same edge
    always_comb begin
        mem_d    = mem_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rvalid_d = re;

        wr_ok = we && !(ZERO_REG && (waddr == '0));
        zero1 = ZERO_REG && (raddr1 == '0);
        zero2 = ZERO_REG && (raddr2 == '0);
        byp1  = wr_ok && (waddr == raddr1);
        byp2  = wr_ok && (waddr == raddr2);

        next1 = zero1 ? '0 : (byp1 ? wdata : mem_q[raddr1]);
        next2 = zero2 ? '0 : (byp2 ? wdata : mem_q[raddr2]);

        if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
        if (re) begin
            rdata1_d = next1;
            rdata2_d = next2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_W;
            end
            if (ZERO_REG) begin
                mem_q[0] <= '0;
            end
            rdata1_q <= INIT_W;
            rdata2_q <= INIT_W;
            rvalid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef REGFILE_TRISTATE_EN
    // Shared-bus hookup: release the operand buses when not selected
    assign rdata1 = oe ? rdata1_q : {WIDTH{1'bz}};
    assign rdata2 = oe ? rdata2_q : {WIDTH{1'bz}};
`else
    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
`endif
    assign rvalid = rvalid_q;

endmodule
